// File: rtl/conv_encoder.sv
// Rate-1/2, K=5 convolutional encoder with a small input FIFO.
// Payload bits are framed into zero-terminated frames (4 tail bits) so the
// downstream Viterbi decoder always restarts from trellis state 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | between frames; outputs 00, first pop starts a new frame
// ST_DATA | inside a frame; one payload bit popped per cycle when available
// ST_TAIL | four zero tail bits flush the window back to state 0
module conv_encoder #(
   parameter logic [4:0] G0         = 5'b11101,
   parameter logic [4:0] G1         = 5'b10011,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       din,
   input  logic       din_valid,
   input  logic       din_last,
   output logic       din_ready,
   output logic [1:0] code_out,
   output logic       code_valid,
   output logic       frame_start,
   output logic       busy,
   output logic       underrun
);

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_TAIL
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     mem_q [FIFO_DEPTH];
   logic [1:0]     mem_d [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic [4:0]     w_q, w_d;
   logic [1:0]     tail_cnt_q, tail_cnt_d;
   logic [1:0]     code_q, code_d;
   logic           code_valid_q, code_valid_d;
   logic           frame_start_q, frame_start_d;
   logic           underrun_q, underrun_d;

   logic           push;
   logic           pop;
   logic           fifo_empty;
   logic [1:0]     head;
   logic           adv;
   logic           bit_in;
   logic           clear_w;
   logic [4:0]     win_next;

   // The oldest tap is consumed as w_q[3] while the next window is formed,
   // so the stored w_q[4] itself never feeds logic.
   logic           unused_oldest;
   assign unused_oldest = w_q[4];

   assign din_ready   = (count_q < FULL_CNT);
   assign push        = din_valid && din_ready;
   assign fifo_empty  = (count_q == '0);
   assign head        = mem_q[rd_ptr_q];

   assign code_out    = code_q;
   assign code_valid  = code_valid_q;
   assign frame_start = frame_start_q;
   assign busy        = (state_q != ST_IDLE);
   assign underrun    = underrun_q;

   // FIFO storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {din_last, din};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Framing FSM, window advance and registered symbol outputs
   always_comb begin
      state_d       = state_q;
      tail_cnt_d    = tail_cnt_q;
      underrun_d    = underrun_q;
      pop           = 1'b0;
      adv           = 1'b0;
      bit_in        = 1'b0;
      clear_w       = 1'b0;
      frame_start_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // code_valid_q high in IDLE means the last tail symbol is still
            // on the output; holding one cycle guarantees an idle 00 symbol
            // between consecutive frames.
            if (!fifo_empty && !code_valid_q) begin
               pop           = 1'b1;
               adv           = 1'b1;
               bit_in        = head[0];
               frame_start_d = 1'b1;
               tail_cnt_d    = 2'd0;
               state_d       = head[1] ? ST_TAIL : ST_DATA;
            end
         end
         ST_DATA: begin
            if (!fifo_empty) begin
               pop    = 1'b1;
               adv    = 1'b1;
               bit_in = head[0];
               if (head[1]) begin
                  tail_cnt_d = 2'd0;
                  state_d    = ST_TAIL;
               end
            end else begin
               underrun_d = 1'b1;
            end
         end
         ST_TAIL: begin
            adv        = 1'b1;
            tail_cnt_d = tail_cnt_q + 1'b1;
            if (tail_cnt_q == 2'd3) begin
               clear_w = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      win_next     = {w_q[3:0], bit_in};
      w_d          = w_q;
      code_d       = 2'b00;
      code_valid_d = 1'b0;
      if (adv) begin
         w_d          = clear_w ? 5'b0 : win_next;
         code_d       = {^(win_next & G1), ^(win_next & G0)};
         code_valid_d = 1'b1;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 2'b00;
         end
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         w_q           <= 5'b0;
         tail_cnt_q    <= 2'd0;
         code_q        <= 2'b00;
         code_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         w_q           <= w_d;
         tail_cnt_q    <= tail_cnt_d;
         code_q        <= code_d;
         code_valid_q  <= code_valid_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

endmodule
